// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one pipelined Wishbone slave.
// Define WB_ARB_TIMEOUT_EN to add the response watchdog and ABORT state.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS*32-1:0]  m_addr_i,
  input  logic [NUM_MASTERS*32-1:0]  m_data_i,
  input  logic [NUM_MASTERS*4-1:0]   m_be_i,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [NUM_MASTERS-1:0]     m_stall_o,
  output logic [31:0]                m_data_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [31:0]                s_addr_o,
  output logic [31:0]                s_data_o,
  output logic [3:0]                 s_be_o,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_stall_i,
  input  logic [31:0]                s_data_i,
  output logic [NUM_MASTERS-1:0]     grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("wb_rr_arbiter: parameter out of range");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ABORT = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;
`endif

  state_t               state;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last;
  logic [CW-1:0]        count;

  logic [31:0] addr_a [NUM_MASTERS];
  logic [31:0] data_a [NUM_MASTERS];
  logic [3:0]  be_a   [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_split
    assign addr_a[k] = m_addr_i[32*k +: 32];
    assign data_a[k] = m_data_i[32*k +: 32];
    assign be_a[k]   = m_be_i[4*k +: 4];
  end

  logic owner_cyc;
  logic active;
  logic full;
  logic resp;
  logic accept;
  logic wd_fire;

  assign owner_cyc = m_cyc_i[owner];
  assign active    = (state == S_GRANT) && owner_cyc;
  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign resp      = active && (count != '0)
                   && (s_ack_i || s_err_i);

  assign s_cyc_o  = active;
  assign s_stb_o  = active && m_stb_i[owner] && !full;
  assign s_we_o   = active && m_we_i[owner];
  assign s_addr_o = active ? addr_a[owner] : '0;
  assign s_data_o = active ? data_a[owner] : '0;
  assign s_be_o   = active ? be_a[owner] : '0;
  assign accept   = s_stb_o && !s_stall_i;

  assign grant_o  = grant_q;
  assign m_data_o = (state == S_GRANT) ? s_data_i : '0;
  assign m_ack_o  = (resp && s_ack_i) ? grant_q : '0;
  assign m_err_o  = ((resp && s_err_i) || wd_fire)
                  ? grant_q : '0;

  // Every non-owner is stalled; the owner sees slave stall or a full window.
  always_comb begin
    m_stall_o = '1;
    if (state == S_GRANT)
      m_stall_o[owner] = s_stall_i || full;
  end

  logic          found;
  logic [IW-1:0] pick;
  logic [IW:0]   sum;

  // Rotating scan starting just after the previous owner.
  always_comb begin
    found = 1'b0;
    pick  = last;
    sum   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      sum = {1'b0, last} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_MASTERS))
        sum = sum - (IW+1)'(NUM_MASTERS);
      if (!found && m_cyc_i[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  logic [WW-1:0] wdog;

  assign wd_fire = active && (count != '0)
                 && !s_ack_i && !s_err_i
                 && (wdog == WW'(TIMEOUT_CYCLES - 1));

  // Count silent cycles while requests are outstanding.
  always_ff @(posedge clk) begin
    if (rst)
      wdog <= '0;
    else if (!active || count == '0 || s_ack_i
             || s_err_i || wd_fire)
      wdog <= '0;
    else
      wdog <= wdog + WW'(1);
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Grant FSM with outstanding-request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= '0;
      owner   <= '0;
      last    <= IW'(NUM_MASTERS - 1);
      count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            state   <= S_GRANT;
            owner   <= pick;
            grant_q <= NUM_MASTERS'(1) << pick;
            count   <= '0;
          end
        end
        S_GRANT: begin
          if (!owner_cyc) begin
            state   <= S_IDLE;
            last    <= owner;
            grant_q <= '0;
            count   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (wd_fire) begin
            state <= S_ABORT;
            count <= '0;
`endif
          end else if (accept && !resp) begin
            count <= count + CW'(1);
          end else if (resp && !accept) begin
            count <= count - CW'(1);
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        S_ABORT: begin
          if (!owner_cyc) begin
            state   <= S_IDLE;
            last    <= owner;
            grant_q <= '0;
            count   <= '0;
          end
        end
        default: state <= S_IDLE;
`endif
      endcase
    end
  end

endmodule
